// File: rtl/morphle_vector_checker.sv
// morphle_vector_checker: replays stored stimulus vectors into a yblock array,
// waits for the response to settle through a 2-flop synchroniser, and
// compares it against a masked expected value. Tracks error count and the
// index of the first failing vector.
module morphle_vector_checker #(
    parameter int DW     = 52,   // vector width driven into the array
    parameter int CW     = 48,   // response width checked
    parameter int DEPTH  = 64,   // vector memory entries
    parameter int SETTLE = 4,    // wait cycles between drive and compare (>= 1)
    parameter int CNT_W  = 16,   // err_count width; saturates at all-ones
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_drive,
    input  logic [CW-1:0]     wr_expect,
    input  logic [CW-1:0]     wr_mask,
    input  logic [AW:0]       nvec,
    input  logic              start,
    input  logic              stop_on_err,
    input  logic              abort,
    output logic [DW-1:0]     dut_in,
    input  logic [CW-1:0]     dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [AW-1:0]     first_err_idx,
    output logic              first_err_valid,
    output logic [AW-1:0]     vec_idx
);

    localparam int EW   = DW + 2 * CW;
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Vector memory: {drive, expect, mask}; intentionally not reset.
    logic [EW-1:0] mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]    vec_idx_q, vec_idx_d;
    logic [AW:0]      nvec_q, nvec_d;
    logic             soe_q, soe_d;
    logic [DW-1:0]    dut_in_q, dut_in_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]    fei_q, fei_d;
    logic             fev_q, fev_d;
    logic             pass_q, pass_d;
    logic             busy_q, done_q;
    logic [CW-1:0]    sync1_q, sync2_q;

    logic [EW-1:0]    rd_s;
    logic [DW-1:0]    drive_s;
    logic [CW-1:0]    exp_s;
    logic [CW-1:0]    mask_s;
    logic             mismatch_s;
    logic             last_s;
    logic [AW:0]      nvec_clamp_s;

    assign rd_s         = mem_q[vec_idx_q];
    assign drive_s      = rd_s[EW-1 -: DW];
    assign exp_s        = rd_s[2*CW-1 -: CW];
    assign mask_s       = rd_s[CW-1:0];
    assign mismatch_s   = |((sync2_q ^ exp_s) & mask_s);
    assign last_s       = (({1'b0, vec_idx_q} + (AW+1)'(1)) == nvec_q);
    assign nvec_clamp_s = (nvec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : nvec;

    // Vector memory write port; locked out while a run is in progress.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en && !busy_q) begin
            mem_q[wr_addr] <= {wr_drive, wr_expect, wr_mask};
        end
    end

    // Next-state and datapath decisions for the run sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_idx_d = vec_idx_q;
        nvec_d    = nvec_q;
        soe_d     = soe_q;
        dut_in_d  = dut_in_q;
        err_d     = err_q;
        fei_d     = fei_q;
        fev_d     = fev_q;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // abort is ignored here, so start always wins
                if (start) begin
                    nvec_d    = nvec_clamp_s;
                    soe_d     = stop_on_err;
                    err_d     = '0;
                    fev_d     = 1'b0;
                    pass_d    = 1'b0;
                    vec_idx_d = '0;
                    if (nvec_clamp_s == '0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_APPLY;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end else begin
                    dut_in_d = drive_s;
                    cnt_d    = CNTW'(SETTLE);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNTW'(1)) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_CHECK: begin
                if (abort) begin
                    // result of this compare is discarded
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch_s) begin
                        if (err_q != {CNT_W{1'b1}}) begin
                            err_d = err_q + CNT_W'(1);
                        end else begin
                            err_d = err_q;
                        end
                        if (!fev_q) begin
                            fei_d = vec_idx_q;
                            fev_d = 1'b1;
                        end else begin
                            fei_d = fei_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (last_s || (mismatch_s && soe_q)) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_idx_d = vec_idx_q + AW'(1);
                        state_d   = S_APPLY;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and status registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vec_idx_q <= '0;
            nvec_q    <= '0;
            soe_q     <= 1'b0;
            dut_in_q  <= '0;
            err_q     <= '0;
            fei_q     <= '0;
            fev_q     <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_idx_q <= vec_idx_d;
            nvec_q    <= nvec_d;
            soe_q     <= soe_d;
            dut_in_q  <= dut_in_d;
            err_q     <= err_d;
            fei_q     <= fei_d;
            fev_q     <= fev_d;
            pass_q    <= pass_d;
            busy_q    <= (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
            done_q    <= (state_d == S_DONE);
            sync1_q   <= dut_out;
            sync2_q   <= sync1_q;
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = fei_q;
    assign first_err_valid = fev_q;
    assign vec_idx         = vec_idx_q;

endmodule

// File: tb/tb_morphle_vector_checker.sv
// Directed bench for morphle_vector_checker: loopback array model on the
// default instance, plus a narrow-counter instance for saturation.
module tb_morphle_vector_checker;

    localparam int DW = 52, CW = 48, DEPTH = 64, SETTLE = 4, AW = 6;
    localparam int VLAT = SETTLE + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_drive = '0;
    logic [CW-1:0] wr_expect = '0;
    logic [CW-1:0] wr_mask = '0;
    logic [AW:0]   nvec = '0;
    logic          start = 1'b0, stop_on_err = 1'b0, abort = 1'b0;
    logic [DW-1:0] dut_in;
    logic [CW-1:0] dut_out;
    logic          busy, done, pass, fev;
    logic [15:0]   err_count;
    logic [AW-1:0] fei, vec_idx;

    // Saturation instance signals
    logic          s_wr_en = 1'b0;
    logic [4:0]    s_wr_addr = '0;
    logic [5:0]    s_nvec = '0;
    logic          s_start = 1'b0;
    logic [3:0]    s_dut_in;
    logic          s_busy, s_done, s_pass, s_fev;
    logic [3:0]    s_err;
    logic [4:0]    s_fei, s_vec_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] loop_f(input logic [DW-1:0] d);
        loop_f = d[CW-1:0] ^ {12{d[DW-1:CW]}};
    endfunction

    function automatic logic [DW-1:0] drive_f(input int i);
        logic [63:0] lo;
        logic [3:0]  hi;
        lo = 64'h0000_1234_5678_9ABC + 64'(i) * 64'h0000_0101_0101_0101;
        hi = 4'(i + 3);
        drive_f = {hi, lo[CW-1:0]};
    endfunction

    assign dut_out = loop_f(dut_in);

    morphle_vector_checker u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_drive(wr_drive),
        .wr_expect(wr_expect), .wr_mask(wr_mask),
        .nvec(nvec), .start(start), .stop_on_err(stop_on_err), .abort(abort),
        .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(fei), .first_err_valid(fev), .vec_idx(vec_idx)
    );

    morphle_vector_checker #(.DW(4), .CW(4), .DEPTH(32), .SETTLE(1), .CNT_W(4)) u_sat (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_drive(4'h5),
        .wr_expect(4'hF), .wr_mask(4'hF),
        .nvec(s_nvec), .start(s_start), .stop_on_err(1'b0), .abort(1'b0),
        .dut_in(s_dut_in), .dut_out(4'h0),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .first_err_idx(s_fei), .first_err_valid(s_fev), .vec_idx(s_vec_idx)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int a, input logic [DW-1:0] d,
                             input logic [CW-1:0] e, input logic [CW-1:0] m);
        wr_en = 1'b1; wr_addr = AW'(a); wr_drive = d; wr_expect = e; wr_mask = m;
        step();
        wr_en = 1'b0;
    endtask

    // abort_at: -1 none, -2 together with start, >=0 cycle index after start
    task automatic run(input int n, input logic soe, input int abort_at,
                       input logic poke, output int cyc);
        nvec = (AW+1)'(n); stop_on_err = soe; start = 1'b1;
        abort = (abort_at == -2);
        step();
        start = 1'b0; abort = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (cyc == abort_at) abort = 1'b1;
            if (poke && cyc == 0) begin
                wr_en = 1'b1; wr_addr = '0; wr_drive = drive_f(0);
                wr_expect = ~loop_f(drive_f(0)); wr_mask = '1;
            end
            step();
            abort = 1'b0; wr_en = 1'b0;
            cyc++;
        end
        if (!done) check_eq("run_timeout", 64'(done), 64'd1);
    endtask

    int cyc;

    initial begin
        // reset state
        step(); step();
        rst = 1'b0;
        check_eq("rst_dut_in", 64'(dut_in), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_pass", 64'(pass), 64'd0);
        check_eq("rst_err", 64'(err_count), 64'd0);
        check_eq("rst_fev", 64'({fev, fei, vec_idx}), 64'd0);

        for (int i = 0; i < DEPTH; i++) write_vec(i, drive_f(i), loop_f(drive_f(i)), '1);

        // good 4-vector run; also a write during busy which must be ignored
        nvec = 7'd4; start = 1'b1; step(); start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("done_after_start", 64'(done), 64'd0);
        repeat (4 * VLAT + 2) step();
        run(4, 1'b0, -1, 1'b1, cyc);
        check_eq("good_cycles", 64'(cyc), 64'(4 * VLAT));
        check_eq("good_pass", 64'(pass), 64'd1);
        check_eq("good_err", 64'(err_count), 64'd0);
        check_eq("good_busy", 64'(busy), 64'd0);
        check_eq("good_vec_idx", 64'(vec_idx), 64'd3);
        check_eq("good_dut_in", 64'(dut_in), 64'(drive_f(3)));
        run(4, 1'b0, -1, 1'b0, cyc);
        check_eq("busy_write_ignored", 64'(pass), 64'd1);

        // vector 2 bit 5 wrong, full mask
        write_vec(2, drive_f(2), loop_f(drive_f(2)) ^ 48'h20, '1);
        run(4, 1'b0, -1, 1'b0, cyc);
        check_eq("bit5_err", 64'(err_count), 64'd1);
        check_eq("bit5_fei", 64'({fev, fei}), 64'({1'b1, 6'd2}));
        check_eq("bit5_pass", 64'(pass), 64'd0);
        check_eq("bit5_cycles", 64'(cyc), 64'(4 * VLAT));
        // same, bit 5 masked off
        write_vec(2, drive_f(2), loop_f(drive_f(2)) ^ 48'h20, ~48'h20);
        run(4, 1'b0, -1, 1'b0, cyc);
        check_eq("bit5_masked_pass", 64'(pass), 64'd1);
        check_eq("bit5_masked_err", 64'(err_count), 64'd0);
        // all-zero mask never mismatches
        write_vec(2, drive_f(2), ~loop_f(drive_f(2)), '0);
        run(4, 1'b0, -1, 1'b0, cyc);
        check_eq("zero_mask_pass", 64'(pass), 64'd1);
        write_vec(2, drive_f(2), loop_f(drive_f(2)), '1);

        // vectors 1 and 3 wrong
        write_vec(1, drive_f(1), loop_f(drive_f(1)) ^ 48'h1, '1);
        write_vec(3, drive_f(3), loop_f(drive_f(3)) ^ 48'h1, '1);
        run(4, 1'b1, -1, 1'b0, cyc);
        check_eq("soe_cycles", 64'(cyc), 64'(2 * VLAT));
        check_eq("soe_err", 64'(err_count), 64'd1);
        check_eq("soe_fei", 64'(fei), 64'd1);
        check_eq("soe_vec_idx", 64'(vec_idx), 64'd1);
        check_eq("soe_pass", 64'(pass), 64'd0);
        run(4, 1'b0, -1, 1'b0, cyc);
        check_eq("nosoe_err", 64'(err_count), 64'd2);
        check_eq("nosoe_fei", 64'(fei), 64'd1);
        check_eq("nosoe_cycles", 64'(cyc), 64'(4 * VLAT));
        write_vec(1, drive_f(1), loop_f(drive_f(1)), '1);
        write_vec(3, drive_f(3), loop_f(drive_f(3)), '1);

        // clamp to DEPTH
        run(DEPTH + 5, 1'b0, -1, 1'b0, cyc);
        check_eq("clamp_cycles", 64'(cyc), 64'(DEPTH * VLAT));
        check_eq("clamp_vec_idx", 64'(vec_idx), 64'(DEPTH - 1));
        check_eq("clamp_pass", 64'(pass), 64'd1);

        // abort during WAIT of vector 1 (cycle VLAT+2 after start)
        run(4, 1'b0, VLAT + 2, 1'b0, cyc);
        check_eq("abort_cycles", 64'(cyc), 64'(VLAT + 3));
        check_eq("abort_pass", 64'(pass), 64'd0);
        check_eq("abort_vec_idx", 64'(vec_idx), 64'd1);
        check_eq("abort_dut_in", 64'(dut_in), 64'(drive_f(1)));
        // start and abort together from DONE: start wins
        run(4, 1'b0, -2, 1'b0, cyc);
        check_eq("start_abort_pass", 64'(pass), 64'd1);
        check_eq("start_abort_cycles", 64'(cyc), 64'(4 * VLAT));

        // reset mid-run
        nvec = 7'd4; start = 1'b1; step(); start = 1'b0;
        repeat (8) step();
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("midrst_outs", 64'({busy, done, pass, fev, err_count, fei, vec_idx}), 64'd0);
        check_eq("midrst_dut_in", 64'(dut_in), 64'd0);

        // nvec = 0 from idle
        run(0, 1'b0, -1, 1'b0, cyc);
        check_eq("nvec0_cycles", 64'(cyc), 64'd0);
        check_eq("nvec0_done_pass", 64'({done, pass, busy}), 64'b110);

        // rerun after reset reproduces result
        run(4, 1'b0, -1, 1'b0, cyc);
        check_eq("rerun_pass", 64'({pass, err_count}), 64'({1'b1, 16'd0}));
        check_eq("rerun_cycles", 64'(cyc), 64'(4 * VLAT));

        // saturation: 4-bit counter, 15 then 32 mismatches
        for (int i = 0; i < 32; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 5'(i); step();
        end
        s_wr_en = 1'b0;
        s_nvec = 6'd15; s_start = 1'b1; step(); s_start = 1'b0;
        for (int k = 0; k < 200 && !s_done; k++) step();
        check_eq("sat_15", 64'(s_err), 64'd15);
        s_nvec = 6'd32; s_start = 1'b1; step(); s_start = 1'b0;
        for (int k = 0; k < 400 && !s_done; k++) step();
        check_eq("sat_done", 64'(s_done), 64'd1);
        check_eq("sat_hold", 64'(s_err), 64'd15);
        check_eq("sat_fei", 64'({s_fev, s_fei, s_pass}), 64'({1'b1, 5'd0, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
